// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous, active-high reset
//   req      - request lines; bit i belongs to requester i
//   gnt_en   - a grant is active this cycle
//   gnt_idx  - index of the current owner; 0 when idle
//   gnt      - one-hot decode of {gnt_en, gnt_idx}
//   busy_cnt - cycles the current owner has held the grant (1 on first cycle); 0 when idle
//
// All outputs are registered. On release (owner drops req or hits MAX_HOLD) the
// search restarts just after the old owner, so the old owner is checked last and
// a handover happens at the same edge with no idle bubble.

module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic       gnt_en,
    output logic [1:0] gnt_idx,
    output logic [3:0] gnt,
    output logic [7:0] busy_cnt
);

    localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic       gnt_en_q, gnt_en_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic [7:0] busy_cnt_q, busy_cnt_d;

    // Circular priority search starting at 'start'. Returns {found, index}.
    // Walking the distances from far to near lets the nearest hit overwrite.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    logic [2:0] sel;
    logic [1:0] search_from;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_en_d    = gnt_en_q;
        gnt_idx_d   = gnt_idx_q;
        busy_cnt_d  = busy_cnt_q;
        search_from = ptr_q;
        sel         = 3'b000;

        unique case (state_q)
            StIdle: begin
                sel = pick(req, ptr_q);
                if (sel[2]) begin
                    state_d    = StGrant;
                    gnt_en_d   = 1'b1;
                    gnt_idx_d  = sel[1:0];
                    busy_cnt_d = 8'd1;
                end
            end
            StGrant: begin
                if (req[gnt_idx_q] && (busy_cnt_q < MaxHold)) begin
                    busy_cnt_d = (busy_cnt_q == 8'hFF) ? busy_cnt_q : busy_cnt_q + 8'd1;
                end else begin
                    // Release: owner goes to the back of the line.
                    search_from = gnt_idx_q + 2'd1;
                    ptr_d       = search_from;
                    sel         = pick(req, search_from);
                    if (sel[2]) begin
                        gnt_en_d   = 1'b1;
                        gnt_idx_d  = sel[1:0];
                        busy_cnt_d = 8'd1;
                    end else begin
                        state_d    = StIdle;
                        gnt_en_d   = 1'b0;
                        gnt_idx_d  = 2'b00;
                        busy_cnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        gnt_d = gnt_en_d ? (4'b0001 << gnt_idx_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= 2'b00;
            gnt_en_q   <= 1'b0;
            gnt_idx_q  <= 2'b00;
            gnt_q      <= 4'b0000;
            busy_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_en_q   <= gnt_en_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_q      <= gnt_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign gnt_en   = gnt_en_q;
    assign gnt_idx  = gnt_idx_q;
    assign gnt      = gnt_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4. Three instances share clock, reset and
// requests; each check looks at the instance whose MAX_HOLD the step targets.

module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic       en8, en2, en1;
    logic [1:0] idx8, idx2, idx1;
    logic [3:0] g8, g2, g1;
    logic [7:0] b8, b2, b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) u8 (
        .clk(clk), .rst(rst), .req(req),
        .gnt_en(en8), .gnt_idx(idx8), .gnt(g8), .busy_cnt(b8)
    );
    rr_arbiter4 #(.MAX_HOLD(2)) u2 (
        .clk(clk), .rst(rst), .req(req),
        .gnt_en(en2), .gnt_idx(idx2), .gnt(g2), .busy_cnt(b2)
    );
    rr_arbiter4 #(.MAX_HOLD(1)) u1 (
        .clk(clk), .rst(rst), .req(req),
        .gnt_en(en1), .gnt_idx(idx1), .gnt(g1), .busy_cnt(b1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {gnt_en, gnt_idx, gnt, busy_cnt} as one vector.
    task automatic check(input string tag,
                         input logic o_en, input logic [1:0] o_idx,
                         input logic [3:0] o_g, input logic [7:0] o_b,
                         input logic e_en, input logic [1:0] e_idx,
                         input logic [3:0] e_g, input logic [7:0] e_b);
        logic [14:0] obs, exp;
        obs = {o_en, o_idx, o_g, o_b};
        exp = {e_en, e_idx, e_g, e_b};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed en=%b idx=%0d gnt=%b busy=%0d expected en=%b idx=%0d gnt=%b busy=%0d",
                   tag, o_en, o_idx, o_g, o_b, e_en, e_idx, e_g, e_b);
        end
    endtask

    logic [1:0] rot_idx [5];
    logic [3:0] rot_gnt [5];
    logic [1:0] sim_idx [6];
    logic [3:0] sim_gnt [6];
    logic [7:0] sim_busy [6];

    initial begin
        rot_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        sim_idx  = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
        sim_gnt  = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0010};
        sim_busy = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};

        // Reset then idle
        rst = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset8", en8, idx8, g8, b8, 1'b0, 2'd0, 4'b0000, 8'd0);
            check("reset1", en1, idx1, g1, b1, 1'b0, 2'd0, 4'b0000, 8'd0);
        end
        rst = 1'b0;
        tick();
        check("idle8", en8, idx8, g8, b8, 1'b0, 2'd0, 4'b0000, 8'd0);

        // Single requester, voluntary release
        req = 4'b0100;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("single_hold", en8, idx8, g8, b8, 1'b1, 2'd2, 4'b0100, 8'(i));
        end
        req = 4'b0000;
        tick();
        check("single_release", en8, idx8, g8, b8, 1'b0, 2'd0, 4'b0000, 8'd0);
        tick();
        check("single_idle", en8, idx8, g8, b8, 1'b0, 2'd0, 4'b0000, 8'd0);

        // Simultaneous requests, MAX_HOLD=2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("simul_mh2", en2, idx2, g2, b2, 1'b1, sim_idx[i], sim_gnt[i], sim_busy[i]);
        end

        // Timeout re-grant of a sole requester
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("timeout_regrant", en8, idx8, g8, b8, 1'b1, 2'd0, 4'b0001, 8'((i % 8) + 1));
        end

        // Rotation, MAX_HOLD=1
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rotate_mh1", en1, idx1, g1, b1, 1'b1, rot_idx[i], rot_gnt[i], 8'd1);
        end

        // Mid-grant reset with ptr moved away from 0
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0010;
        tick();
        check("pre_owner1", en8, idx8, g8, b8, 1'b1, 2'd1, 4'b0010, 8'd1);
        req = 4'b0100;
        tick();
        check("handover_to2", en8, idx8, g8, b8, 1'b1, 2'd2, 4'b0100, 8'd1);
        for (int i = 0; i < 4; i++) tick();
        check("owner2_busy5", en8, idx8, g8, b8, 1'b1, 2'd2, 4'b0100, 8'd5);
        rst = 1'b1;
        req = 4'b1111;
        tick();
        check("midgrant_reset", en8, idx8, g8, b8, 1'b0, 2'd0, 4'b0000, 8'd0);
        rst = 1'b0;
        tick();
        check("post_reset_ptr0", en8, idx8, g8, b8, 1'b1, 2'd0, 4'b0001, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one resource slot.
- Produces a registered 2-bit grant index plus an enable. It also outputs the matching one-hot grant vector, which is the same mapping as the team's 2-to-4 enable decoder.
- Sits in front of any shared datapath: requesters raise req, the arbiter sequences ownership and bounds hold time.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request lines; bit i = requester i
- gnt_en  output  1  a grant is active this cycle
- gnt_idx  output  2  index of current owner; 0 when gnt_en=0
- gnt  output  4  one-hot grant; gnt[gnt_idx]=1 when gnt_en=1, else 4'b0000
- busy_cnt  output  8  cycles the current owner has held the grant, starting at 1 on the first grant cycle; 0 when idle

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered and update only on the rising edge of clk.
- Reset (rst=1 sampled at an edge) sets:
  - gnt_en=0, gnt_idx=2'b00, gnt=4'b0000, busy_cnt=0
  - state=IDLE, priority pointer ptr=0
- Reset has priority over every other event, including mid-grant: the grant drops at the edge that samples rst=1.
- States:
  - IDLE: no owner.
    - If req!=0, select the first set bit searching circularly from ptr (ptr, ptr+1, ..., ptr+3 mod 4).
    - Grant it at the next edge: gnt_en=1, busy_cnt=1, go to GRANT.
    - Latency: req sampled at edge N gives grant visible after edge N (one cycle).
    - If req==0, stay in IDLE.
  - GRANT: owner o=gnt_idx.
    - Continue condition: req[o]=1 and busy_cnt<MAX_HOLD. Keep the owner and increment busy_cnt (saturating at 255).
    - Release condition: req[o]=0 (voluntary release) or busy_cnt==MAX_HOLD (timeout).
- Release handling:
  - On release, set ptr=(o+1) mod 4 and search req circularly from (o+1) mod 4, with o checked last.
  - Handover has no bubble: the new owner's grant appears at the same edge the old grant ends, with busy_cnt=1 and state remaining GRANT.
  - Voluntary release: o's own bit is 0, so it cannot be re-selected. If no other request exists, go to IDLE with gnt_en=0 and busy_cnt=0.
  - Timeout with o as the sole requester: o is re-granted with busy_cnt=1. No idle cycle is inserted.
- MAX_HOLD=1: re-arbitration happens every cycle; with all requesters active, grants rotate 0,1,2,3,0,...
- Simultaneous requests in IDLE: the lowest circular distance from ptr wins.
- Requests arriving during GRANT do not pre-empt the owner; they are considered only at release.
- Invariants:
  - gnt is always exactly the decode of {gnt_en, gnt_idx}.
  - gnt_en=1 implies gnt has exactly one bit set.
  - A grant is never issued to a requester whose req bit was 0 at the deciding edge.
- Fairness: with all four requesting continuously, each requester is granted within 3*MAX_HOLD+1 cycles of its request.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=4'b0000 → gnt_en=0, gnt=0000, gnt_idx=0, busy_cnt=0 every cycle.
- Single requester, MAX_HOLD=8: req=4'b0100 held for 3 cycles then dropped → gnt=0100 for 3 cycles with busy_cnt 1,2,3, then gnt=0000 and IDLE.
- Simultaneous requests:
  - From reset, req=4'b1010 continuous, MAX_HOLD=2 → grants 1,1,3,3,1,1,3,3...
  - gnt_idx sequence 01,01,11,11, with no bubble at handover.
- Timeout re-grant: req=4'b0001 held for 20 cycles, MAX_HOLD=8 → gnt=0001 continuously.
  - busy_cnt runs 1..8, then 1..8, then 1..4.
- Rotation with MAX_HOLD=1: req=4'b1111 → gnt sequence 0001,0010,0100,1000,0001; each requester is served within 4 cycles.
- Mid-grant reset: owner 2 at busy_cnt=5, assert rst for one cycle with req=4'b1111 → outputs clear at that edge.
  - The next grant goes to requester 0, since ptr has reset to 0.
